// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and TX FIFO write port shared by the round-robin arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   valid_i;
  logic [N_REQ-1:0]   last_i;
  logic [8*N_REQ-1:0] data_i;
  logic [N_REQ-1:0]   ready_o;
  logic               tx_fifo_full_i;
  logic [7:0]         data_tx_o;
  logic               tx_fifo_write_o;

  modport master (
    output valid_i, last_i, data_i, tx_fifo_full_i,
    input  ready_o, data_tx_o, tx_fifo_write_o
  );

  modport slave (
    input  valid_i, last_i, data_i, tx_fifo_full_i,
    output ready_o, data_tx_o, tx_fifo_write_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter for the UART TX FIFO write port.
// Optional stall-timeout release enabled by defining TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned MAX_BURST      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             flush_i,
  uart_tx_arbiter_if.slave bus,
  output logic [N_REQ-1:0] gnt_o,
  output logic             busy_o,
  output logic             timeout_o
);
  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB_IDLE, ARB_GRANT} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [IW-1:0]    gidx_inc;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic [IW:0]      scan_sum;
  logic             in_grant;
  logic             wr;
  logic             rel;
  logic             timeout_d;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          timeout_q;
`else
  // Without the stall counter the timeout depth has no effect.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  assign in_grant = (state_q == ARB_GRANT);
  assign wr       = in_grant & bus.valid_i[gidx_q] & ~bus.tx_fifo_full_i & ~flush_i;
  assign cnt_inc  = cnt_q + 1'b1;
  assign gidx_inc = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  assign bus.ready_o         = (in_grant & ~bus.tx_fifo_full_i & ~flush_i) ? gnt_q : '0;
  assign bus.tx_fifo_write_o = wr;
  assign bus.data_tx_o       = in_grant ? bus.data_i[{gidx_q, 3'b000} +: 8] : '0;
  assign gnt_o               = gnt_q;
  assign busy_o              = in_grant;

  // First valid requester at or after the rr pointer, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_q} + (IW + 1)'(i);
      if (scan_sum >= (IW + 1)'(N_REQ)) scan_sum = scan_sum - (IW + 1)'(N_REQ);
      if (!win_found && bus.valid_i[scan_sum[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    rel       = 1'b0;
    timeout_d = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    stall_d   = stall_q;
`endif
    if (flush_i) begin
      state_d = ARB_IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
`ifdef TX_ARB_TIMEOUT_EN
      stall_d = '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (enable_i && win_found) begin
            state_d = ARB_GRANT;
            gnt_d   = N_REQ'(1) << win_idx;
            gidx_d  = win_idx;
            cnt_d   = '0;
          end
        end
        ARB_GRANT: begin
          if (wr) begin
            cnt_d = cnt_inc;
            if (bus.last_i[gidx_q] || (cnt_inc == CW'(MAX_BURST))) rel = 1'b1;
          end
`ifdef TX_ARB_TIMEOUT_EN
          // Only cycles with the granted requester idle count as stall.
          if (bus.valid_i[gidx_q]) begin
            stall_d = '0;
          end else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
            rel       = 1'b1;
            timeout_d = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
`endif
          if (rel) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
            rr_d    = gidx_inc;
`ifdef TX_ARB_TIMEOUT_EN
            stall_d = '0;
`endif
          end
        end
        default: begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
`ifdef TX_ARB_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_d;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=8, TIMEOUT_CYCLES=64).
module tb_uart_tx_arbiter;
  localparam int unsigned N = 4;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         enable_i;
  logic         flush_i;
  logic [N-1:0] gnt_o;
  logic         busy_o;
  logic         timeout_o;
  int           checks   = 0;
  int           failures = 0;
  int           bc [N];

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ          (N),
    .MAX_BURST      (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .enable_i  (enable_i),
    .flush_i   (flush_i),
    .bus       (bus),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] d);
    chk({tag, "_wr"}, bus.tx_fifo_write_o, 1);
    chk({tag, "_data"}, bus.data_tx_o, d);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_byte(input int k, input logic [7:0] d, input logic l);
    bus.data_i[8*k +: 8] = d;
    bus.last_i[k]        = l;
  endtask

  // Requester k sends bytes {k, n}; every second byte closes its burst.
  task automatic drive_all();
    for (int k = 0; k < N; k++) set_byte(k, 8'((k << 4) | bc[k]), bc[k][0]);
  endtask

  task automatic do_reset();
    bus.valid_i = '0;
    bus.last_i  = '0;
    bus.tx_fifo_full_i = 1'b0;
    flush_i  = 1'b0;
    enable_i = 1'b1;
    rst_n_i  = 1'b0;
    #3;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
  endtask

  initial begin
    int g;
    logic [7:0] n0;
    for (int k = 0; k < N; k++) bc[k] = 0;
    rst_n_i = 1'b0; enable_i = 1'b1; flush_i = 1'b0;
    bus.valid_i = '0; bus.last_i = '0; bus.data_i = '0; bus.tx_fifo_full_i = 1'b0;
    #12;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_wr", bus.tx_fifo_write_o, 0);
    chk("rst_data", bus.data_tx_o, 0);
    chk("rst_timeout", timeout_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();

    // single requester 1, three bytes
    bus.valid_i = 4'b0010; set_byte(1, 8'h11, 1'b0); #1;
    chk("t1_idle_wr", bus.tx_fifo_write_o, 0);
    tick();
    chk("t1_gnt", gnt_o, 4'b0010);
    chk("t1_busy", busy_o, 1);
    chk("t1_ready", bus.ready_o, 4'b0010);
    chk_wr("t1_b0", 8'h11);
    tick(); set_byte(1, 8'h22, 1'b0); #1;
    chk("t1_gnt_held", gnt_o, 4'b0010);
    chk_wr("t1_b1", 8'h22);
    tick(); set_byte(1, 8'h33, 1'b1); #1;
    chk_wr("t1_b2", 8'h33);
    tick(); bus.valid_i = '0; bus.last_i = '0; #1;
    chk("t1_rel_gnt", gnt_o, 0);
    chk("t1_rel_busy", busy_o, 0);
    // rr pointer now at 2: with all valid, requester 2 wins
    bus.valid_i = 4'b1111; drive_all(); bus.last_i = '1; #1;
    chk("t1_gap_wr", bus.tx_fifo_write_o, 0);
    tick();
    chk("t1_rr2_gnt", gnt_o, 4'b0100);
    chk("t1_rr2_data", bus.data_tx_o, 8'h20);
    // asynchronous reset in the middle of a grant
    #2; rst_n_i = 1'b0; #1;
    chk("rst_async_gnt", gnt_o, 0);
    chk("rst_async_wr", bus.tx_fifo_write_o, 0);
    do_reset();

    // all four requesters, 2-byte bursts, rr from 0
    bus.valid_i = 4'b1111; drive_all(); #1;
    for (int b = 0; b < 5; b++) begin
      g = b % N;
      chk("t2_gap_busy", busy_o, 0);
      chk("t2_gap_wr", bus.tx_fifo_write_o, 0);
      tick();
      chk("t2_gnt", gnt_o, 32'(1 << g));
      chk("t2_ready", bus.ready_o, 32'(1 << g));
      chk_wr("t2_b0", 8'((g << 4) | bc[g]));
      tick(); bc[g]++; drive_all(); #1;
      chk("t2_gnt_held", gnt_o, 32'(1 << g));
      chk_wr("t2_b1", 8'((g << 4) | bc[g]));
      tick(); bc[g]++; drive_all(); #1;
    end
    do_reset();

    // MAX_BURST forced release, then requester 0 resumes
    n0 = 8'd1;
    bus.valid_i = 4'b0011; set_byte(0, n0, 1'b0); set_byte(1, 8'hA1, 1'b1); #1;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("t3_gnt0", gnt_o, 4'b0001);
      for (int j = 0; j < 8; j++) begin
        chk_wr("t3_b", n0);
        tick(); n0++; set_byte(0, n0, 1'b0); #1;
      end
      chk("t3_maxrel_gnt", gnt_o, 0);
      chk("t3_maxrel_wr", bus.tx_fifo_write_o, 0);
      if (r == 0) begin
        tick();
        chk("t3_gnt1", gnt_o, 4'b0010);
        chk_wr("t3_r1", 8'hA1);
        tick(); bus.valid_i[1] = 1'b0; #1;
        chk("t3_r1_rel", gnt_o, 0);
      end
    end
    tick();
    chk("t3_gnt0_again", gnt_o, 4'b0001);
    chk_wr("t3_b17", 8'd17);

    // FIFO full stall for 5 cycles mid-burst
    tick(); set_byte(0, 8'd18, 1'b0); bus.tx_fifo_full_i = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_full_wr", bus.tx_fifo_write_o, 0);
      chk("t4_full_ready", bus.ready_o, 0);
      chk("t4_full_gnt", gnt_o, 4'b0001);
      tick();
    end
    bus.tx_fifo_full_i = 1'b0;
    for (int n = 18; n <= 20; n++) begin
      set_byte(0, 8'(n), n == 20); #1;
      chk_wr("t4_b", 8'(n));
      tick();
    end
    bus.valid_i = '0; bus.last_i = '0; #1;
    chk("t4_rel_gnt", gnt_o, 0);
    do_reset();

    // flush mid-burst, enable gating, rr unchanged
    bus.valid_i = 4'b0001; set_byte(0, 8'h0F, 1'b1); #1;
    tick();
    chk_wr("t5_r0", 8'h0F);
    tick(); bus.valid_i = '0; bus.last_i = '0; #1;
    chk("t5_r0_rel", gnt_o, 0);
    bus.valid_i = 4'b0100; set_byte(2, 8'h51, 1'b0); #1;
    tick();
    chk("t5_gnt2", gnt_o, 4'b0100);
    chk_wr("t5_b1", 8'h51);
    tick(); set_byte(2, 8'h52, 1'b0); enable_i = 1'b0; #1;
    chk_wr("t5_b2_en_low", 8'h52);
    tick(); set_byte(2, 8'h53, 1'b0); flush_i = 1'b1; #1;
    chk("t5_flush_wr", bus.tx_fifo_write_o, 0);
    chk("t5_flush_ready", bus.ready_o, 0);
    tick(); flush_i = 1'b0; #1;
    chk("t5_flush_gnt", gnt_o, 0);
    chk("t5_flush_busy", busy_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_en_block", gnt_o, 0);
    end
    bus.valid_i = 4'b0101; set_byte(0, 8'h01, 1'b0); enable_i = 1'b1; #1;
    tick();
    chk("t5_rr_kept", gnt_o, 4'b0100);
    chk_wr("t5_b3", 8'h53);
    flush_i = 1'b1; tick(); flush_i = 1'b0; bus.valid_i = '0;
    do_reset();

    // granted requester goes silent
    bus.valid_i = 4'b1000; set_byte(3, 8'h77, 1'b0); #1;
    tick();
    chk("t6_gnt", gnt_o, 4'b1000);
    bus.valid_i = '0; #1;
    chk("t6_stall_wr", bus.tx_fifo_write_o, 0);
`ifdef TX_ARB_TIMEOUT_EN
    for (int i = 1; i < 64; i++) begin
      tick();
      chk("t6_hold", gnt_o, 4'b1000);
      chk("t6_no_to", timeout_o, 0);
    end
    tick();
    chk("t6_to_gnt", gnt_o, 0);
    chk("t6_to_pulse", timeout_o, 1);
    tick();
    chk("t6_to_end", timeout_o, 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("t6_hold", gnt_o, 4'b1000);
      chk("t6_no_to", timeout_o, 0);
    end
    flush_i = 1'b1; tick(); flush_i = 1'b0; #1;
    chk("t6_flush_gnt", gnt_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the UART transmitter's single TX FIFO write port (8-bit data plus a write strobe) among N_REQ byte-stream requesters, e.g. the CPU register interface, the receiver echo path and the protocol/ack generator.
- A granted requester owns the port for one burst, so its bytes reach the serial line contiguously.
- The burst ends on its last byte, after MAX_BURST bytes, or on flush.
- Sits between the requesters and the transmitter; reacts to FIFO full, enable and configuration flush.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 8, max bytes written per grant before forced release (1..255)
TIMEOUT_CYCLES, 64, stall cycles before forced release (used only with optional feature)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  transmitter enable; low blocks new grants
flush_i  in  1  synchronous abort (slave configuration request)
valid_i  in  N_REQ  per-requester byte valid
last_i  in  N_REQ  per-requester last byte of burst, qualified by valid
data_i  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]
ready_o  out  N_REQ  per-requester accept; a byte transfers when valid&ready
tx_fifo_full_i  in  1  TX FIFO full flag from transmitter
data_tx_o  out  8  byte to TX FIFO
tx_fifo_write_o  out  1  TX FIFO write strobe
gnt_o  out  N_REQ  one-hot registered grant
busy_o  out  1  high while a grant is held
timeout_o  out  1  one-cycle pulse on timeout release

Behaviour:
- Reset values: state ARB_IDLE, gnt_o=0, rr pointer=0, burst count=0, busy_o=0, ready_o=0, tx_fifo_write_o=0, data_tx_o=0, timeout_o=0.
- ARB_IDLE:
  - If enable_i=1, flush_i=0 and any valid_i is high, pick the first valid requester scanning from the rr pointer upward with wrap-around.
  - Register the winner into gnt_o and go to ARB_GRANT next cycle.
  - No writes occur in ARB_IDLE.
- ARB_GRANT (g = granted index):
  - ready_o[g] = !tx_fifo_full_i. All other ready_o bits = 0.
  - tx_fifo_write_o = valid_i[g] & !tx_fifo_full_i, combinational from registered state.
  - data_tx_o = data_i[g], muxed combinationally.
  - Latency: valid sampled in IDLE at cycle n; first write at cycle n+1 if FIFO not full.
  - Burst count increments on each write.
  - Release when a write occurs with last_i[g]=1, or when the write makes count==MAX_BURST. If both happen together, release once.
  - On release: next state ARB_IDLE, gnt_o=0, count=0, rr pointer=(g+1) mod N_REQ.
  - Minimum one idle cycle between bursts.
- FIFO full: no write and no count advance; grant is held.
- valid_i[g] low mid-burst: grant is held; other requesters wait.
- enable_i low in ARB_GRANT: the burst continues. enable_i only gates new grants.
- flush_i, any state: next cycle ARB_IDLE, gnt_o=0, count=0, rr pointer unchanged, no write in the flush cycle.
- Counter width: $clog2(MAX_BURST+1).
- N_REQ=1 is not supported.
- Reset mid-burst: immediate return to reset values.

Optional Feature:
Macro: TX_ARB_TIMEOUT_EN
- With the macro defined:
  - A stall counter counts consecutive ARB_GRANT cycles with valid_i[g]=0. FIFO-full cycles with valid high do not count.
  - It clears on any cycle with valid_i[g]=1.
  - When it reaches TIMEOUT_CYCLES, the grant is released as a normal release (rr pointer advances) and timeout_o pulses for one cycle.
- Without the macro: no stall counter, timeout_o tied 0, TIMEOUT_CYCLES ignored.

Test Plan:
- Single requester 1: valid with bytes 0x11,0x22,0x33 (last on 0x33), FIFO never full -> gnt_o=4'b0010 one cycle after valid; three consecutive writes; release; rr pointer=2.
- All 4 requesters valid continuously, each sending 2-byte bursts -> grant order 0,1,2,3,0; one idle cycle between bursts; no byte interleaving.
- Requester 0 streams 20 bytes without last, MAX_BURST=8 -> release after the 8th write; requester 1 (also valid) granted next; requester 0 resumes at byte 17 on its next turn.
- tx_fifo_full_i high for 5 cycles mid-burst -> tx_fifo_write_o=0 and ready_o=0 during the stall; count frozen; remaining bytes in order after full drops.
- flush_i asserted during the write of byte 3 of 5 -> no write that cycle; ARB_IDLE next cycle; rr pointer unchanged; enable_i=0 afterwards blocks any new grant.
- TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64: granted requester drops valid -> release and timeout_o pulse exactly 64 cycles later; without the macro the grant is held indefinitely.
